sprinkler_zone_encoder: RTL and testbench

SPRINKLER_ZONE_ENCODER -- requirements
Module: sprinkler_zone_encoder

---
 rtl/sprinkler_zone_encoder.sv | 190 +++++++++++++++++++
 tb/tb_sprinkler_zone_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprinkler_zone_encoder.sv
// -----------------------------------------------------------------------------
// sprinkler_zone_encoder
//
// Purpose: serves up to eight irrigation zone requests one at a time. Zones
// are chosen round-robin, each selected zone is held open for DWELL clock
// cycles, and the selection is presented as a 3-to-8 decoder drive
// (enable E plus index A/B/C).
//
// Optional feature, macro SPRINKLER_ENC_GAP_EN:
//   When defined, one break-before-make cycle (E=0, busy=1, index already
//   showing the next zone) is inserted between consecutive zones, including
//   when the same zone is reselected. When undefined, the GAP state does not
//   exist and zones follow each other back-to-back.
//
// Ports:
//   clk        in   single clock, rising-edge active
//   rst        in   synchronous active-high reset
//   req[7:0]   in   per-zone watering requests, bit i = zone i
//   E          out  decoder enable, 1 = selected valve open
//   A, B, C    out  selected zone index, A = MSB, C = LSB
//   busy       out  1 whenever the FSM is not idle
//   zone_done  out  one-cycle pulse on the final enabled cycle of a zone
//
// All outputs come straight from flops, so req has no combinational path to
// any output.
// -----------------------------------------------------------------------------
module sprinkler_zone_encoder #(
  parameter int DWELL = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic       E,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       zone_done
);

`ifdef SPRINKLER_ENC_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
`endif

  // The dwell counter runs DWELL-1 .. 0, so a zone is open for DWELL cycles.
  localparam logic [7:0] LP_LOAD = 8'(DWELL - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [2:0] r_last,  w_last_nxt;
  logic [2:0] r_zone,  w_zone_nxt;
  logic       r_en,    w_en_nxt;
  logic       r_busy,  w_busy_nxt;
  logic       r_done,  w_done_nxt;

  logic       w_found;
  logic [2:0] w_sel;
  logic [2:0] w_idx;

  // Round-robin search starting one past the last served zone. The offset
  // of 8 wraps back onto r_last itself, so the current zone is the final
  // candidate. Selection is only ever used when w_found is set, which keeps
  // the valve from opening on an index nobody asked for.
  always_comb begin : rr_search
    w_found = 1'b0;
    w_sel   = 3'd0;
    w_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      w_idx = r_last + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_zone_nxt  = r_zone;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = LP_LOAD;
          w_last_nxt  = w_sel;
          w_zone_nxt  = w_sel;
          w_en_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = 8'd0;
          w_zone_nxt  = 3'd0;
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end

      ST_RUN: begin
        if (r_cnt != 8'd0) begin
          // A started zone always runs out; req is not looked at here.
          w_cnt_nxt  = r_cnt - 8'd1;
          w_done_nxt = (r_cnt == 8'd1);
        end else if (w_found) begin
`ifdef SPRINKLER_ENC_GAP_EN
          // Close the valve for one cycle while the index already shows the
          // next zone; the dwell count is loaded on the way out of GAP.
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = 8'd0;
          w_last_nxt  = w_sel;
          w_zone_nxt  = w_sel;
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
`else
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = LP_LOAD;
          w_last_nxt  = w_sel;
          w_zone_nxt  = w_sel;
          w_en_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
          w_zone_nxt  = 3'd0;
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end

`ifdef SPRINKLER_ENC_GAP_EN
      ST_GAP: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = LP_LOAD;
        w_en_nxt    = 1'b1;
        w_busy_nxt  = 1'b1;
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
        w_zone_nxt  = 3'd0;
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin : fsm_regs
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_last  <= 3'd7;
      r_zone  <= 3'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_zone  <= w_zone_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign E         = r_en;
  assign A         = r_zone[2];
  assign B         = r_zone[1];
  assign C         = r_zone[0];
  assign busy      = r_busy;
  assign zone_done = r_done;

endmodule

// File: tb/tb_sprinkler_zone_encoder.sv
// -----------------------------------------------------------------------------
// tb_sprinkler_zone_encoder
//
// Bench for sprinkler_zone_encoder with DWELL=4. Expected output vectors
// {E, A, B, C, busy, zone_done} are queued when a scenario's stimulus is
// planned and popped one per clock as the DUT produces outputs. Inputs are
// changed 1 ns after the rising edge and outputs are sampled at that point.
// Define SPRINKLER_ENC_GAP_EN for both files to check the GAP build.
// -----------------------------------------------------------------------------
module tb_sprinkler_zone_encoder;

  localparam int DWELL = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       E, A, B, C, busy, zone_done;

  logic [5:0] exp_q[$];
  logic [8:0] stim_q[$];  // {rst, req} per cycle
  int         n_tests;
  int         n_fail;

  sprinkler_zone_encoder #(.DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .E         (E),
    .A         (A),
    .B         (B),
    .C         (C),
    .busy      (busy),
    .zone_done (zone_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expectation builders ----------------
  task automatic push_run(input logic [2:0] zone);
    for (int k = 0; k < DWELL; k++)
      exp_q.push_back({1'b1, zone, 1'b1, (k == DWELL - 1)});
  endtask

  task automatic push_gap(input logic [2:0] zone);
`ifdef SPRINKLER_ENC_GAP_EN
    exp_q.push_back({1'b0, zone, 1'b1, 1'b0});
`else
    if (zone > 3'd7) $display("unreachable");
`endif
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(6'b000000);
  endtask

  // Held request for the first n_act cycles, then zero.
  task automatic push_held(input logic [7:0] pat, input int n_act, input int n_tot);
    for (int k = 0; k < n_tot; k++)
      stim_q.push_back({1'b0, (k < n_act) ? pat : 8'h00});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [5:0] obs_v, exp_v;
    stim_q.push_back({1'b1, 8'hFF});   // req ignored while rst is high
    stim_q.push_back({1'b1, 8'h5A});
    stim_q.push_back({1'b0, 8'h00});
    stim_q.push_back({1'b0, 8'h00});
    push_idle(4);
    while (stim_q.size() > 0) begin
      {rst, req} = stim_q.pop_front();
      @(posedge clk); #1;
      obs_v = {E, A, B, C, busy, zone_done};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset: got EABC_busy_done=%b expected %b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_single();
    logic [5:0] obs_v, exp_v;
    push_run(3'd0);
    push_idle(2);
    push_held(8'h01, 1, DWELL + 2);
    while (stim_q.size() > 0) begin
      {rst, req} = stim_q.pop_front();
      @(posedge clk); #1;
      obs_v = {E, A, B, C, busy, zone_done};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL single_zone0: got %b expected %b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs_v, exp_v;
    int n_act;
    push_run(3'd2);
    push_gap(3'd7);
    push_run(3'd7);
    push_gap(3'd2);
    push_run(3'd2);
    n_act = exp_q.size();
    push_idle(2);
    push_held(8'b1000_0100, n_act, exp_q.size());
    while (stim_q.size() > 0) begin
      {rst, req} = stim_q.pop_front();
      @(posedge clk); #1;
      obs_v = {E, A, B, C, busy, zone_done};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back: got %b expected %b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_same_zone();
    logic [5:0] obs_v, exp_v;
    int n_act;
    push_run(3'd5);
    push_gap(3'd5);
    push_run(3'd5);
    push_gap(3'd5);
    push_run(3'd5);
    n_act = exp_q.size();
    push_idle(2);
    push_held(8'b0010_0000, n_act, exp_q.size());
    while (stim_q.size() > 0) begin
      {rst, req} = stim_q.pop_front();
      @(posedge clk); #1;
      obs_v = {E, A, B, C, busy, zone_done};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL same_zone: got %b expected %b", obs_v, exp_v);
      end
    end
  endtask

  // Zone 3 starts, rst arrives in its second cycle. Afterwards zones 3 and 4
  // are both requested: a search from zone 0 picks 3, a stale last=3 would
  // pick 4.
  task automatic test_reset_mid_run();
    logic [5:0] obs_v, exp_v;
    stim_q.push_back({1'b0, 8'h08});
    stim_q.push_back({1'b0, 8'h00});
    stim_q.push_back({1'b1, 8'hFF});
    exp_q.push_back({1'b1, 3'd3, 1'b1, 1'b0});
    exp_q.push_back({1'b1, 3'd3, 1'b1, 1'b0});
    push_idle(1);
    push_run(3'd3);
    push_idle(2);
    push_held(8'h18, 1, DWELL + 2);
    while (stim_q.size() > 0) begin
      {rst, req} = stim_q.pop_front();
      @(posedge clk); #1;
      obs_v = {E, A, B, C, busy, zone_done};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_run: got %b expected %b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_all_zones();
    logic [5:0] obs_v, exp_v;
    int n_act;
    stim_q.push_back({1'b1, 8'h00});
    push_idle(1);
    for (int z = 0; z < 8; z++) begin
      if (z > 0) push_gap(3'(z));
      push_run(3'(z));
    end
    push_gap(3'd0);
    push_run(3'd0);
    n_act = exp_q.size() - 1;
    push_idle(2);
    push_held(8'hFF, n_act, exp_q.size() - 1);
    while (stim_q.size() > 0) begin
      {rst, req} = stim_q.pop_front();
      @(posedge clk); #1;
      obs_v = {E, A, B, C, busy, zone_done};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL all_zones: got %b expected %b", obs_v, exp_v);
      end
    end
  endtask

  // Random single-zone bursts: one request bit for one cycle, any zone.
  task automatic test_random();
    logic [5:0] obs_v, exp_v;
    int z;
    for (int it = 0; it < 8; it++) begin
      z = $urandom_range(0, 7);
      push_held(8'(1 << z), 1, DWELL + 1);
      push_run(3'(z));
      push_idle(1);
    end
    while (stim_q.size() > 0) begin
      {rst, req} = stim_q.pop_front();
      @(posedge clk); #1;
      obs_v = {E, A, B, C, busy, zone_done};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_zone: got %b expected %b", obs_v, exp_v);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req     = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_same_zone();
    test_reset_mid_run();
    test_all_zones();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
